// File: rtl/immediate_encoder.sv
// immediate_encoder: packs a signed immediate into the imm fields of a 32-bit
// RV64 instruction template (I/S/B/U/J). It checks range and alignment, and can
// expand an out-of-range I-type immediate into a LUI + I-type pair.
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   req_valid_in / req_ready_out     request handshake (ready decoded from state)
//   imm_signal_in [2:0]              format select (IMM_*_TYPE below)
//   imm_value_in [XLEN-1:0]          signed immediate
//   instr_in [31:0]                  instruction template
//   expand_in                        permit LUI+I expansion for this request
//   instr_valid_out / instr_ready_in output beat handshake
//   instr_out [31:0], err_out        registered beat payload
module immediate_encoder #(
  parameter int unsigned XLEN      = 64,
  parameter bit          EXPAND_EN = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [2:0]      imm_signal_in,
  input  logic [XLEN-1:0] imm_value_in,
  input  logic [31:0]     instr_in,
  input  logic            expand_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [31:0]     instr_out,
  output logic            err_out
);

  localparam logic [2:0] IMM_I_TYPE = 3'd0;
  localparam logic [2:0] IMM_S_TYPE = 3'd1;
  localparam logic [2:0] IMM_U_TYPE = 3'd2;
  localparam logic [2:0] IMM_J_TYPE = 3'd3;
  localparam logic [2:0] IMM_B_TYPE = 3'd4;

  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_HI   = 2'd2,
    S_LO   = 2'd3
  } state_t;

  // True when v[XLEN-1:k] are all equal, i.e. v fits in a (k+1)-bit signed field.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned k);
    logic [XLEN-1:0] s;
    s = XLEN'($signed(v) >>> k);
    return (s == '0) || (s == '1);
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_second, w_second_nxt;

  logic        w_legal;
  logic        w_exp_ok;
  logic [31:0] w_enc;
  logic [31:0] w_zero;
  logic [19:0] w_hi;
  logic [31:0] w_lui;
  logic [31:0] w_lo_instr;
  logic [31:0] w_first;
  logic        w_first_err;
  logic        w_accept;
  logic        w_take;

  // Format encoder: legal encoding and the imm-zeroed error form of the template.
  always_comb begin
    w_legal = 1'b0;
    w_enc   = instr_in;
    w_zero  = instr_in;
    case (imm_signal_in)
      IMM_I_TYPE: begin
        w_legal = fits_signed(imm_value_in, 11);
        w_enc   = {imm_value_in[11:0], instr_in[19:0]};
        w_zero  = {12'b0, instr_in[19:0]};
      end
      IMM_S_TYPE: begin
        w_legal = fits_signed(imm_value_in, 11);
        w_enc   = {imm_value_in[11:5], instr_in[24:12], imm_value_in[4:0], instr_in[6:0]};
        w_zero  = {7'b0, instr_in[24:12], 5'b0, instr_in[6:0]};
      end
      IMM_U_TYPE: begin
        w_legal = fits_signed(imm_value_in, 31) && (imm_value_in[11:0] == 12'b0);
        w_enc   = {imm_value_in[31:12], instr_in[11:0]};
        w_zero  = {20'b0, instr_in[11:0]};
      end
      IMM_B_TYPE: begin
        w_legal = fits_signed(imm_value_in, 12) && !imm_value_in[0];
        w_enc   = {imm_value_in[12], imm_value_in[10:5], instr_in[24:12],
                   imm_value_in[4:1], imm_value_in[11], instr_in[6:0]};
        w_zero  = {7'b0, instr_in[24:12], 5'b0, instr_in[6:0]};
      end
      IMM_J_TYPE: begin
        w_legal = fits_signed(imm_value_in, 20) && !imm_value_in[0];
        w_enc   = {imm_value_in[20], imm_value_in[10:1], imm_value_in[11],
                   imm_value_in[19:12], instr_in[11:0]};
        w_zero  = {20'b0, instr_in[11:0]};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Expansion: v in [-2^31, 2^31-2049]; the top 2048 values would overflow hi+v[11].
  always_comb begin
    w_exp_ok = EXPAND_EN && expand_in && (imm_signal_in == IMM_I_TYPE) && !w_legal &&
               fits_signed(imm_value_in, 31) &&
               !(!imm_value_in[31] && (&imm_value_in[30:11]));
    // Compensate for the sign-extended low 12 bits added by the I-type beat.
    w_hi       = imm_value_in[31:12] + 20'(imm_value_in[11]);
    w_lui      = {w_hi, instr_in[11:7], OPC_LUI};
    w_lo_instr = {imm_value_in[11:0], instr_in[11:7], instr_in[14:0]};
    w_first    = w_exp_ok ? w_lui : (w_legal ? w_enc : w_zero);
    w_first_err = !w_legal && !w_exp_ok;
  end

  assign req_ready_out = (r_state == S_IDLE) ||
                         (((r_state == S_ONE) || (r_state == S_LO)) && instr_ready_in);

  // Next-state and output-register logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = r_instr;
    w_err_nxt    = r_err;
    w_second_nxt = r_second;
    w_accept     = req_valid_in && req_ready_out;
    w_take       = r_valid && instr_ready_in;
    case (r_state)
      S_IDLE, S_ONE, S_LO: begin
        if (w_accept) begin
          w_state_nxt  = w_exp_ok ? S_HI : S_ONE;
          w_instr_nxt  = w_first;
          w_err_nxt    = w_first_err;
          w_second_nxt = w_lo_instr;
        end else if ((r_state != S_IDLE) && w_take) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HI: begin
        if (w_take) begin
          w_state_nxt = S_LO;
          w_instr_nxt = r_second;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_valid_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_instr  <= 32'b0;
      r_err    <= 1'b0;
      r_second <= 32'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_err    <= w_err_nxt;
      r_second <= w_second_nxt;
    end
  end

  assign instr_valid_out = r_valid;
  assign instr_out       = r_instr;
  assign err_out         = r_err;

endmodule
